// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for the MIPS core.
// Sequences a shared-memory, single-ALU datapath (IR, ALUOut, MDR) over
// 3-5 cycles per instruction and stalls on the memory-ready handshake.
// Optional feature macro: MC_PERF_CNT_EN (cycle / retired-instruction
// counters); when undefined both counter ports are tied to zero.
//
// Memory handshake: the FSM presents a request (IorD, MemWrite) and holds it
// stable; mem_ready=1 means the memory accepted that request in this cycle.
// Only the accepting cycle advances the FSM, loads IR/PC, or retires a store.

module mc_controller (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        pc_en,
    output logic [1:0]  PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ImmSign,
    output logic [2:0]  ALUControl,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUSrcB selections
    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // PCSrc selections
    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JTA    = 2'b10;

    state_t state_q;
    state_t state_d;

    // Decoded instruction information (IR is stable from DECODE onward)
    logic       r_legal;
    logic [2:0] r_alu;
    logic       is_mem;
    logic       is_branch;
    logic       is_itype;
    logic       is_jump;
    logic [2:0] i_alu;
    logic       i_sign;

    // Raw (un-gated) enables and pulses produced by the state decode
    logic irwrite_raw;
    logic memwrite_raw;
    logic pc_en_raw;
    logic regwrite_raw;
    logic retire_raw;
    logic illegal_raw;

    // R-type function decode: legality and ALU operation
    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            default: r_legal = 1'b0;
        endcase
    end

    // Opcode class decode plus I-type ALU operation and immediate extension
    always_comb begin
        is_mem    = 1'b0;
        is_branch = 1'b0;
        is_itype  = 1'b0;
        is_jump   = 1'b0;
        i_alu     = ALU_ADD;
        i_sign    = 1'b1;
        case (op)
            OP_LW, OP_SW:   is_mem = 1'b1;
            OP_BEQ, OP_BNE: is_branch = 1'b1;
            OP_ADDI: begin
                is_itype = 1'b1;
                i_alu    = ALU_ADD;
                i_sign   = 1'b1;
            end
            OP_SLTI: begin
                is_itype = 1'b1;
                i_alu    = ALU_SLT;
                i_sign   = 1'b1;
            end
            OP_ANDI: begin
                is_itype = 1'b1;
                i_alu    = ALU_AND;
                i_sign   = 1'b0;
            end
            OP_ORI: begin
                is_itype = 1'b1;
                i_alu    = ALU_OR;
                i_sign   = 1'b0;
            end
            OP_J:    is_jump = 1'b1;
            default: ;
        endcase
    end

    // State register: reset abandons any in-flight instruction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs, qualified by op/funct/zero/mem_ready
    always_comb begin
        state_d      = state_q;
        IorD         = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        pc_en_raw    = 1'b0;
        PCSrc        = PC_ALURES;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_RT;
        ImmSign      = 1'b0;
        ALUControl   = ALU_AND;
        regwrite_raw = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        retire_raw   = 1'b0;
        illegal_raw  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed by the ALU; IR and PC load only on accept
                ALUSrcB     = SRCB_FOUR;
                ALUControl  = ALU_ADD;
                irwrite_raw = mem_ready;
                pc_en_raw   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ALUSrcB    = SRCB_BOFF;
                ALUControl = ALU_ADD;
                if (is_mem) begin
                    state_d = S_MEMADR;
                end else if ((op == OP_RTYPE) && r_legal) begin
                    state_d = S_EXEC;
                end else if (is_branch) begin
                    state_d = S_BRANCH;
                end else if (is_itype) begin
                    state_d = S_IEXEC;
                end else if (is_jump) begin
                    state_d = S_JUMP;
                end else begin
                    illegal_raw = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ImmSign    = 1'b1;
                ALUControl = ALU_ADD;
                state_d    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg     = 1'b1;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe held until accepted; the store retires then
                IorD         = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) begin
                    retire_raw = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUControl = r_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst       = 1'b1;
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                // Compare rs/rt; take the BTA held in ALUOut when the test holds
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RT;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                pc_en_raw  = (op == OP_BNE) ? !zero : zero;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ImmSign    = i_sign;
                ALUControl = i_alu;
                state_d    = S_IWB;
            end
            S_IWB: begin
                regwrite_raw = 1'b1;
                retire_raw   = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = PC_JTA;
                pc_en_raw  = 1'b1;
                retire_raw = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with every enable low
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables and pulses are forced low while reset is asserted
    always_comb begin
        IRWrite  = irwrite_raw  & rstn;
        MemWrite = memwrite_raw & rstn;
        pc_en    = pc_en_raw    & rstn;
        RegWrite = regwrite_raw & rstn;
        retire   = retire_raw   & rstn;
        illegal  = illegal_raw  & rstn;
    end

    assign state = state_q;

`ifdef MC_PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter, both wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized scoreboard bench for mc_controller.
// The driver walks each instruction through the per-cycle behaviour it
// should have, pushing one expected control vector per clock into exp_q;
// the monitor pops and compares on the falling edge.
// Counter expectations follow MC_PERF_CNT_EN (zero when undefined).

module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        IorD;
  logic        IRWrite;
  logic        MemWrite;
  logic        pc_en;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ImmSign;
  logic [2:0]  ALUControl;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        retire;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  localparam int W = 86;
  // Control bits that must read 0 while reset is held:
  // IRWrite(16) MemWrite(15) pc_en(14) RegWrite(4) retire(1) illegal(0)
  localparam logic [21:0] EN_MASK = 22'h1C013;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] act_v;
  int vec_cnt = 0;
  int err_cnt = 0;
  int unsigned m_cyc = 0;
  int unsigned m_ins = 0;

  mc_controller dut (
    .clk(clk), .rstn(rstn), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .IorD(IorD), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .pc_en(pc_en), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSign(ImmSign),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .retire(retire), .illegal(illegal),
    .state(state), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog: the run must complete within a bounded time
  initial begin
    #5_000_000;
    err_cnt++;
    $display("FAIL timeout: wait expired after %0t, %0d vectors pending", $time, exp_q.size());
    $display("== TEST FAILED (%0d errors) ==", err_cnt);
    $finish;
  end

  // Expected control vector layout (MSB first)
  function automatic logic [21:0] ctl(
    input logic [3:0] st, input bit iord, input bit irw, input bit mw,
    input bit pce, input bit [1:0] pcs, input bit srca, input bit [1:0] srcb,
    input bit ims, input bit [2:0] alu, input bit rw, input bit rd,
    input bit m2r, input bit ret, input bit ill);
    return {st, iord, irw, mw, pce, pcs, srca, srcb, ims, alu, rw, rd, m2r, ret, ill};
  endfunction

  // Per-cycle behaviour of each instruction step
  function automatic logic [21:0] t_fetch(input bit mr);
    return ctl(4'd0, 0, mr, 0, mr, 2'b00, 0, 2'b01, 0, 3'b010, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] t_decode(input bit ill);
    return ctl(4'd1, 0, 0, 0, 0, 2'b00, 0, 2'b11, 0, 3'b010, 0, 0, 0, 0, ill);
  endfunction
  function automatic logic [21:0] t_memadr();
    return ctl(4'd2, 0, 0, 0, 0, 2'b00, 1, 2'b10, 1, 3'b010, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] t_memrd();
    return ctl(4'd3, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] t_memwb();
    return ctl(4'd4, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 1, 1, 0);
  endfunction
  function automatic logic [21:0] t_memwr(input bit mr);
    return ctl(4'd5, 1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 3'b000, 0, 0, 0, mr, 0);
  endfunction
  function automatic logic [21:0] t_exec(input bit [2:0] alu);
    return ctl(4'd6, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, alu, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] t_aluwb();
    return ctl(4'd7, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 1, 0, 1, 0);
  endfunction
  function automatic logic [21:0] t_branch(input bit take);
    return ctl(4'd8, 0, 0, 0, take, 2'b01, 1, 2'b00, 0, 3'b110, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [21:0] t_iexec(input bit sgn, input bit [2:0] alu);
    return ctl(4'd9, 0, 0, 0, 0, 2'b00, 1, 2'b10, sgn, alu, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [21:0] t_iwb();
    return ctl(4'd10, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 3'b000, 1, 0, 0, 1, 0);
  endfunction
  function automatic logic [21:0] t_jump();
    return ctl(4'd11, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 3'b000, 0, 0, 0, 1, 0);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] perf(input int unsigned v);
`ifdef MC_PERF_CNT_EN
    return v;
`else
    return (v == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Drive one clock cycle and queue what the DUT must show during it
  task automatic cyc(input bit r, input bit mr, input bit z, input logic [21:0] c);
    rstn      = r;
    mem_ready = mr;
    zero      = z;
    if (!r) begin
      c     = c & ~EN_MASK;
      m_cyc = 0;
      m_ins = 0;
    end
    exp_q.push_back({c, perf(m_cyc), perf(m_ins)});
    if (r) begin
      m_cyc++;
      if (c[1]) m_ins++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(0, rb(), rb(), t_fetch(1));
  endtask

  // Issue one instruction: fs fetch stalls, ms memory stalls
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input bit z,
                       input int fs, input int ms);
    logic [2:0] ralu;
    logic [2:0] ialu;
    bit         isgn;
    bit         rlegal;
    int         cls;   // 0 illegal, 1 lw, 2 sw, 3 R, 4 branch, 5 I-ALU, 6 j
    rlegal = 1'b1;
    ralu   = 3'b010;
    case (f)
      6'b100000: ralu = 3'b010;
      6'b100010: ralu = 3'b110;
      6'b100100: ralu = 3'b000;
      6'b100101: ralu = 3'b001;
      6'b101010: ralu = 3'b111;
      default:   rlegal = 1'b0;
    endcase
    ialu = 3'b010;
    isgn = 1'b1;
    case (o)
      6'b000000: cls = rlegal ? 3 : 0;
      6'b100011: cls = 1;
      6'b101011: cls = 2;
      6'b000100, 6'b000101: cls = 4;
      6'b001000: begin cls = 5; ialu = 3'b010; isgn = 1'b1; end
      6'b001010: begin cls = 5; ialu = 3'b111; isgn = 1'b1; end
      6'b001100: begin cls = 5; ialu = 3'b000; isgn = 1'b0; end
      6'b001101: begin cls = 5; ialu = 3'b001; isgn = 1'b0; end
      6'b000010: cls = 6;
      default:   cls = 0;
    endcase
    op    = o;
    funct = f;
    for (int k = 0; k < fs; k++) cyc(1, 0, rb(), t_fetch(0));
    cyc(1, 1, rb(), t_fetch(1));
    cyc(1, rb(), rb(), t_decode(cls == 0));
    case (cls)
      1: begin
        cyc(1, rb(), rb(), t_memadr());
        for (int k = 0; k < ms; k++) cyc(1, 0, rb(), t_memrd());
        cyc(1, 1, rb(), t_memrd());
        cyc(1, rb(), rb(), t_memwb());
      end
      2: begin
        cyc(1, rb(), rb(), t_memadr());
        for (int k = 0; k < ms; k++) cyc(1, 0, rb(), t_memwr(0));
        cyc(1, 1, rb(), t_memwr(1));
      end
      3: begin
        cyc(1, rb(), rb(), t_exec(ralu));
        cyc(1, rb(), rb(), t_aluwb());
      end
      4: cyc(1, rb(), z, t_branch((o == 6'b000101) ? !z : z));
      5: begin
        cyc(1, rb(), rb(), t_iexec(isgn, ialu));
        cyc(1, rb(), rb(), t_iwb());
      end
      6: cyc(1, rb(), rb(), t_jump());
      default: ;
    endcase
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {state, IorD, IRWrite, MemWrite, pc_en, PCSrc, ALUSrcA, ALUSrcB,
               ImmSign, ALUControl, RegWrite, RegDst, MemtoReg, retire, illegal,
               cycle_cnt, instr_cnt};
      vec_cnt++;
      if (act_v !== exp_v) begin
        err_cnt++;
        $display("FAIL ctrl_vec t=%0t got=%h exp=%h (state got %0d exp %0d)",
                 $time, act_v, exp_v, act_v[W-1 -: 4], exp_v[W-1 -: 4]);
      end
    end
  end

  logic [5:0] legal_ops [12];
  logic [5:0] legal_fn  [5];

  // Stimulus
  initial begin
    logic [5:0] o;
    logic [5:0] f;
    legal_ops = '{6'b000000, 6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    legal_fn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rstn      = 1'b1;
    op        = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;

    // Reset-state check: FETCH, all enables/pulses low, counters zero
    vec_cnt++;
    if (state !== 4'd0 || IRWrite !== 1'b0 || MemWrite !== 1'b0 || pc_en !== 1'b0 ||
        RegWrite !== 1'b0 || retire !== 1'b0 || illegal !== 1'b0 ||
        cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_state t=%0t state=%0d IRWrite=%b MemWrite=%b pc_en=%b RegWrite=%b retire=%b illegal=%b cyc=%0d ins=%0d",
               $time, state, IRWrite, MemWrite, pc_en, RegWrite, retire, illegal,
               cycle_cnt, instr_cnt);
    end

    reset_cycles(3);

    // Directed cases
    issue(6'b100011, 6'd0, 0, 0, 0);          // lw: 0,1,2,3,4
    issue(6'b101011, 6'd7, 0, 0, 3);          // sw, 3 MEMWR stalls
    issue(6'b000100, 6'd0, 1, 0, 0);          // beq taken
    issue(6'b000101, 6'd0, 1, 0, 0);          // bne not taken
    issue(6'b000100, 6'd0, 0, 1, 0);          // beq not taken
    issue(6'b000101, 6'd0, 0, 0, 0);          // bne taken
    issue(6'b001101, 6'd0, 0, 0, 0);          // ori
    issue(6'b001010, 6'd0, 0, 0, 0);          // slti
    issue(6'b001000, 6'd0, 0, 0, 0);          // addi
    issue(6'b001100, 6'd0, 0, 0, 0);          // andi
    for (int k = 0; k < 5; k++) issue(6'b000000, legal_fn[k], 0, 0, 0);
    issue(6'b111111, 6'd0, 0, 0, 0);          // illegal op
    issue(6'b000000, 6'b000000, 0, 0, 0);     // illegal funct
    issue(6'b100011, 6'd0, 0, 2, 2);          // lw with stalls

    // Ten jumps from reset
    reset_cycles(2);
    for (int k = 0; k < 10; k++) issue(6'b000010, 6'($urandom), 0, 0, 0);

    // Reset in the middle of a stalled store: strobe must drop at once
    op = 6'b101011;
    cyc(1, 1, rb(), t_fetch(1));
    cyc(1, rb(), rb(), t_decode(0));
    cyc(1, rb(), rb(), t_memadr());
    cyc(1, 0, rb(), t_memwr(0));
    cyc(1, 0, rb(), t_memwr(0));
    reset_cycles(2);
    issue(6'b000000, 6'b100000, 0, 0, 0);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else o = legal_ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      else f = legal_fn[$urandom_range(0, 4)];
      issue(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) reset_cycles(1);
    end

    @(negedge clk);
    #1;

    // Drain check: every queued expectation must have been compared
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d expected vectors never compared", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    if (err_cnt == 0) $display("== TEST PASSED ==");
    else $display("== TEST FAILED (%0d errors) ==", err_cnt);
    $finish;
  end

endmodule
